// File: rtl/token_window_counter_if.sv
// Result handshake bundle for token_window_counter: window totals, valid/ready and the sticky overflow flag.
interface token_window_counter_if #(
    parameter int CNT_W = 5
);
    logic [CNT_W-1:0] cnt;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             overflow;

    modport master (
        output cnt,
        output cnt_valid,
        output overflow,
        input  cnt_ready
    );

    modport slave (
        input  cnt,
        input  cnt_valid,
        input  overflow,
        output cnt_ready
    );
endinterface

// File: rtl/token_window_counter.sv
// Counts '1' tokens over windows of WINDOW enabled cycles and queues each total in a DEPTH-entry FIFO.
// Optional macro TOKEN_WINDOW_CLR_EN adds a clr input that restarts the window and clears overflow.
module token_window_counter #(
    parameter  int WINDOW = 16,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
`ifdef TOKEN_WINDOW_CLR_EN
    input  logic clr,
`endif
    token_window_counter_if.master res
);

    localparam int TMR_W = $clog2(WINDOW);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             overflow_q, overflow_d;

    logic             clr_i;
    logic             win_end;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic [CNT_W-1:0] total;

`ifdef TOKEN_WINDOW_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    // Timer runs down from WINDOW-1; reaching zero on an enabled cycle closes the window.
    always_comb begin
        win_end  = en && (timer_q == '0);
        total    = acc_q + CNT_W'(a);
        push_req = win_end && !clr_i;
        full     = (occ_q == OCC_FULL);
        pop      = (occ_q != '0) && res.cnt_ready;
        push_ok  = push_req && (!full || pop);

        timer_d = timer_q;
        acc_d   = acc_q;
        if (clr_i) begin
            timer_d = TMR_LAST;
            acc_d   = '0;
        end else if (en) begin
            if (win_end) begin
                timer_d = TMR_LAST;
                acc_d   = '0;
            end else begin
                timer_d = timer_q - TMR_ONE;
                acc_d   = total;
            end
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = total;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        // A full FIFO with a simultaneous pop still accepts the new total.
        overflow_d = overflow_q;
        if (clr_i) begin
            overflow_d = 1'b0;
        end else if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q    <= TMR_LAST;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    assign res.cnt       = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign res.cnt_valid = (occ_q != '0);
    assign res.overflow  = overflow_q;

endmodule

// File: doc/token_window_counter.md
Name: token_window_counter

Overview:
- Serial-token consumer that sits directly downstream of the token-halving stage and takes its 1-bit output stream.
- Counts '1' tokens over fixed windows of WINDOW enabled cycles.
- Pushes each window total into a small result FIFO.
- Delivers the totals to a parallel consumer through a valid/ready handshake, with a sticky overflow flag for lost results.

Parameters:
- WINDOW, 16, enabled cycles per counting window; legal range >= 2.
- DEPTH, 4, result FIFO entries; power of two, >= 2.
- CNT_W, $clog2(WINDOW+1), width of a window total; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; the window timer and accumulator update only when en=1.
- a  input  1  serial token stream; one token per cycle when a=1 and en=1.
- cnt  output  CNT_W  window total at FIFO head.
- cnt_valid  output  1  FIFO not empty.
- cnt_ready  input  1  consumer accepts cnt.
- overflow  output  1  sticky: a window total was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at posedge): timer=0, acc=0, FIFO emptied, cnt=0, cnt_valid=0, overflow=0. Reset overrides every other event in the same cycle, including a mid-window reset; the partial window is discarded.
- en=0: timer and acc hold; a is ignored; FIFO pop still operates.
- en=1, timer < WINDOW-1: acc <= acc + a; timer <= timer + 1.
- en=1, timer == WINDOW-1 (last window cycle):
  - total = acc + a, computed at CNT_W bits; no truncation, since max = WINDOW.
  - total is pushed to the FIFO.
  - acc <= 0; timer <= 0.
- Push-to-output latency:
  - The total is in the FIFO after the last-window-cycle edge.
  - If the FIFO was empty, cnt_valid=1 and cnt=total in the cycle immediately following that edge.
- Pop: occurs at the edge where cnt_valid=1 and cnt_ready=1.
- Output stability: while cnt_valid=1 and cnt_ready=0, cnt is held stable.
- cnt_valid may not drop without a pop, except on reset.
- cnt when empty: cnt=0 (registered head or zero-masked; it must read 0 when cnt_valid=0).
- FIFO full and push with no pop in the same cycle: total is dropped; overflow <= 1; FIFO contents unchanged.
- FIFO full and push with pop in the same cycle: both occur; push accepted; no overflow.
- FIFO empty and push with cnt_ready=1: no pop that cycle (nothing valid); entry appears next cycle.
- Pointers: wrap modulo DEPTH; an extra occupancy bit or count distinguishes full from empty.
- overflow: stays 1 until rst.
- Timer wrap: exactly at WINDOW-1 -> 0; never exceeds WINDOW-1.

Optional Feature:
- Macro: TOKEN_WINDOW_CLR_EN.
- With the macro defined:
  - Extra input port clr (1 bit).
  - clr=1 at posedge: acc <= 0; timer <= 0; overflow <= 0; no push that cycle, even if timer == WINDOW-1.
  - FIFO contents and pop behaviour are unaffected.
  - rst has priority over clr.
- Without the macro: no clr port; overflow clears only on rst.

Test Plan (WINDOW=4, DEPTH=2 unless noted):
- Reset, then en=1, a=1, cnt_ready=1 for 8 cycles -> cnt_valid first high after the 4th enabled edge; two totals cnt=4, cnt=4 accepted; overflow=0.
- en=1, cnt_ready=1, a=1,0,1,1 then 0,0,0,0 -> totals 3 then 0, in order.
- a=1 held, en=1,0,1,0,1,0,1,0 -> exactly one total cnt=4 after the 4th enabled cycle; en=0 cycles neither counted nor advance the timer.
- cnt_ready=0, a=1, en=1 for 12 cycles -> FIFO holds 4,4; third total dropped; overflow=1. Then cnt_ready=1 -> pops 4,4; cnt_valid=0 afterwards; overflow stays 1 until rst.
- FIFO full (cnt_ready=0), raise cnt_ready=1 exactly on the last cycle of the next window (a=1,1,0,1) -> pop and push in the same cycle; FIFO then holds 4,3; overflow remains 0.
- After 2 counted tokens, assert rst for 1 cycle mid-window, then a=1,0,0,0 -> cnt_valid=0 during and after reset until the next full window; first total=1.
- With TOKEN_WINDOW_CLR_EN: pulse clr at timer=2 after tokens 1,1 -> no push; next window starts from 0.
